// File: rtl/ptc_sar_tracker.sv
// Phase-tuning SAR with optional +/-1 tracking and lock detection.
// Drives segmented coarse/fine1/fine2 thermometer codes to the delay line.
module ptc_sar_tracker #(
    parameter int CODE_W     = 10,
    parameter int COARSE_W   = 4,
    parameter int FINE1_W    = 3,
    parameter int SETTLE_CYC = 4,
    parameter int LOCK_CNT   = 8
) (
    input  logic                                        clk_ext,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic                                        track_en,
    input  logic                                        comp,
    output logic [CODE_W-1:0]                           code,
    output logic                                        busy,
    output logic                                        sar_done,
    output logic                                        lock,
    output logic                                        sat_hi,
    output logic                                        sat_lo,
    output logic [2**COARSE_W-1:0]                      therm_c,
    output logic [2**COARSE_W-1:0]                      therm_c_b,
    output logic [2**FINE1_W-1:0]                       therm_f1,
    output logic [2**FINE1_W-1:0]                       therm_f1_b,
    output logic [2**(CODE_W-COARSE_W-FINE1_W)-1:0]     therm_f2,
    output logic [2**(CODE_W-COARSE_W-FINE1_W)-1:0]     therm_f2_b
);

    localparam int F2_W  = CODE_W - COARSE_W - FINE1_W;
    localparam int C_N   = 2**COARSE_W;
    localparam int F1_N  = 2**FINE1_W;
    localparam int F2_N  = 2**F2_W;
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int PTR_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam int ALT_W = $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [PTR_W-1:0]  PTR_TOP    = PTR_W'(CODE_W - 1);
    localparam logic [ALT_W-1:0]  ALT_LOCK   = ALT_W'(LOCK_CNT);
    localparam logic [CODE_W-1:0] CODE_MSB   = {1'b1, {(CODE_W-1){1'b0}}};
    localparam logic [CODE_W-1:0] CODE_MAX   = {CODE_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE, SETTLE, DECIDE, TSETTLE, TDECIDE, HOLD
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [PTR_W-1:0]  ptr;
    logic [ALT_W-1:0]  alt_cnt;
    logic [ALT_W-1:0]  alt_next;
    logic              prev_up;

    logic [C_N-1:0]    therm_c_d;
    logic [F1_N-1:0]   therm_f1_d;
    logic [F2_N-1:0]   therm_f2_d;
    logic [COARSE_W-1:0] seg_c;
    logic [FINE1_W-1:0]  seg_f1;
    logic [F2_W-1:0]     seg_f2;

    assign seg_c  = code[CODE_W-1 -: COARSE_W];
    assign seg_f1 = code[F2_W +: FINE1_W];
    assign seg_f2 = code[F2_W-1:0];

    // Alternation run length: a reversal extends the run, a repeat restarts it at 1.
    // Saturating at LOCK_CNT keeps the counter from wrapping during long locks.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        alt_next   = ALT_W'(1);
        therm_c_d  = '0;
        therm_f1_d = '0;
        therm_f2_d = '0;
        if (comp != prev_up)
            alt_next = (alt_cnt == ALT_LOCK) ? alt_cnt : alt_cnt + 1'b1;
        for (int i = 0; i < C_N; i++)
            therm_c_d[i] = (i < int'(seg_c));
        for (int i = 0; i < F1_N; i++)
            therm_f1_d[i] = (i < int'(seg_f1));
        for (int i = 0; i < F2_N; i++)
            therm_f2_d[i] = (i < int'(seg_f2));
    end

    always_ff @(posedge clk_ext) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (rst) begin
            therm_c    <= '0;
            therm_c_b  <= '1;
            therm_f1   <= '0;
            therm_f1_b <= '1;
            therm_f2   <= '0;
            therm_f2_b <= '1;
        end else begin
            therm_c    <= therm_c_d;
            therm_c_b  <= ~therm_c_d;
            therm_f1   <= therm_f1_d;
            therm_f1_b <= ~therm_f1_d;
            therm_f2   <= therm_f2_d;
            therm_f2_b <= ~therm_f2_d;
        end
    end

    always_ff @(posedge clk_ext) begin
        if (rst) begin
            state    <= IDLE;
            code     <= '0;
            cnt      <= '0;
            ptr      <= '0;
            alt_cnt  <= '0;
            prev_up  <= 1'b0;
            busy     <= 1'b0;
            sar_done <= 1'b0;
            lock     <= 1'b0;
            sat_hi   <= 1'b0;
            sat_lo   <= 1'b0;
        end else if (start) begin
            state    <= SETTLE;
            code     <= CODE_MSB;
            cnt      <= CNT_RELOAD;
            ptr      <= PTR_TOP;
            alt_cnt  <= '0;
            busy     <= 1'b1;
            sar_done <= 1'b0;
            lock     <= 1'b0;
            sat_hi   <= 1'b0;
            sat_lo   <= 1'b0;
        end else begin
            sar_done <= 1'b0;
            case (state)
                IDLE: ;
                SETTLE: begin
                    if (cnt == '0) state <= DECIDE;
                    else           cnt   <= cnt - 1'b1;
                end
                DECIDE: begin
                    code[ptr] <= comp;
                    cnt       <= CNT_RELOAD;
                    if (ptr != '0) begin
                        code[ptr - 1'b1] <= 1'b1;
                        ptr              <= ptr - 1'b1;
                        state            <= SETTLE;
                    end else begin
                        sar_done <= 1'b1;
                        busy     <= 1'b0;
                        state    <= track_en ? TSETTLE : HOLD;
                    end
                end
                TSETTLE: begin
                    if (cnt == '0) state <= TDECIDE;
                    else           cnt   <= cnt - 1'b1;
                end
                TDECIDE: begin
                    prev_up <= comp;
                    cnt     <= CNT_RELOAD;
                    state   <= track_en ? TSETTLE : HOLD;
                    // A blocked step at either rail breaks the alternation run.
                    if (comp && code == CODE_MAX) begin
                        sat_hi  <= 1'b1;
                        sat_lo  <= 1'b0;
                        alt_cnt <= '0;
                    end else if (!comp && code == '0) begin
                        sat_hi  <= 1'b0;
                        sat_lo  <= 1'b1;
                        alt_cnt <= '0;
                    end else begin
                        code    <= comp ? code + 1'b1 : code - 1'b1;
                        sat_hi  <= 1'b0;
                        sat_lo  <= 1'b0;
                        alt_cnt <= alt_next;
                        if (alt_next >= ALT_LOCK) lock <= 1'b1;
                    end
                end
                HOLD: begin
                    if (track_en) begin
                        cnt   <= CNT_RELOAD;
                        state <= TSETTLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ptc_sar_tracker.sv
// Self-checking bench for ptc_sar_tracker at default parameters: constant vector table,
// corner-case sequences, and randomized comp checked against a step-level model.
module tb_ptc_sar_tracker;

    logic        clk_ext = 1'b0;
    logic        rst, start, track_en, comp;
    logic [9:0]  code;
    logic        busy, sar_done, lock, sat_hi, sat_lo;
    logic [15:0] therm_c, therm_c_b;
    logic [7:0]  therm_f1, therm_f1_b, therm_f2, therm_f2_b;

    ptc_sar_tracker dut (
        .clk_ext    (clk_ext),
        .rst        (rst),
        .start      (start),
        .track_en   (track_en),
        .comp       (comp),
        .code       (code),
        .busy       (busy),
        .sar_done   (sar_done),
        .lock       (lock),
        .sat_hi     (sat_hi),
        .sat_lo     (sat_lo),
        .therm_c    (therm_c),
        .therm_c_b  (therm_c_b),
        .therm_f1   (therm_f1),
        .therm_f1_b (therm_f1_b),
        .therm_f2   (therm_f2),
        .therm_f2_b (therm_f2_b)
    );

    always #5 clk_ext = ~clk_ext;

    typedef struct {
        int          target;
        logic [9:0]  exp_code;
        logic [15:0] exp_c;
        logic [7:0]  exp_f1;
        logic [7:0]  exp_f2;
    } vec_t;

    vec_t vecs[6];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_ext);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // comp follows a threshold comparator; lat = edges from start to sar_done, -1 on timeout
    task automatic run_sar(input int target, output int lat);
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            comp = (int'(code) < target);
            tick();
            if (sar_done) begin
                lat = n;
                break;
            end
        end
    endtask

    int lat, bad, sat_seen;
    int sar_val, m_code, run, early;
    logic lk, sh, sl, prev, cb, te;
    logic [31:0] exp_state, exp_c, exp_f1, exp_f2;

    initial begin
        vecs[0] = '{600,  10'd599,  16'h01FF, 8'h03, 8'h7F};
        vecs[1] = '{0,    10'd0,    16'h0000, 8'h00, 8'h00};
        vecs[2] = '{1024, 10'd1023, 16'h7FFF, 8'h7F, 8'h7F};
        vecs[3] = '{513,  10'd512,  16'h00FF, 8'h00, 8'h00};
        vecs[4] = '{100,  10'd99,   16'h0001, 8'h0F, 8'h07};
        vecs[5] = '{345,  10'd344,  16'h001F, 8'h07, 8'h00};

        rst = 1'b1; start = 1'b0; track_en = 1'b0; comp = 1'b0;
        do_reset();
        check("reset_code",  32'(code), 32'd0);
        check("reset_flags", 32'({busy, sar_done, lock, sat_hi, sat_lo}), 32'd0);
        check("reset_therm", 32'({therm_c, therm_f1, therm_f2}), 32'd0);
        check("reset_therm_b", 32'({therm_c_b, therm_f1_b, therm_f2_b}), 32'hFFFF_FFFF);

        // Threshold table: SAR result, latency and thermometer decode
        for (int v = 0; v < 6; v++) begin
            do_reset();
            track_en = 1'b0;
            do_start();
            run_sar(vecs[v].target, lat);
            check($sformatf("tab%0d_latency", v), 32'(lat), 32'd50);
            check($sformatf("tab%0d_code", v), 32'(code), 32'(vecs[v].exp_code));
            tick();
            check($sformatf("tab%0d_therm_c", v), 32'(therm_c), 32'(vecs[v].exp_c));
            check($sformatf("tab%0d_therm_f1", v), 32'(therm_f1), 32'(vecs[v].exp_f1));
            check($sformatf("tab%0d_therm_f2", v), 32'(therm_f2), 32'(vecs[v].exp_f2));
            check($sformatf("tab%0d_therm_b", v), 32'({therm_c_b, therm_f1_b, therm_f2_b}),
                  ~32'({vecs[v].exp_c, vecs[v].exp_f1, vecs[v].exp_f2}));
            check($sformatf("tab%0d_busy", v), 32'(busy), 32'd0);
        end

        // Tracking around 600: alternating 600/599, lock on the 8th alternating step
        do_reset();
        track_en = 1'b1;
        do_start();
        run_sar(600, lat);
        sat_seen = 0;
        for (int k = 1; k <= 12; k++) begin
            for (int t = 0; t < 5; t++) begin
                comp = (int'(code) < 600);
                tick();
                sat_seen += int'(sat_hi | sat_lo);
            end
            check($sformatf("track_code_step%0d", k), 32'(code), (k % 2 == 1) ? 32'd600 : 32'd599);
            check($sformatf("track_lock_step%0d", k), 32'(lock), (k >= 8) ? 32'd1 : 32'd0);
        end
        check("track_sat_seen", 32'(sat_seen), 32'd0);

        // Reset while locked, then IDLE ignores comp
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_lock_code", 32'(code), 32'd0);
        check("rst_lock_flags", 32'({busy, lock, sat_hi, sat_lo}), 32'd0);
        check("rst_lock_therm_c_b", 32'(therm_c_b), 32'h0000_FFFF);
        bad = 0;
        for (int t = 0; t < 20; t++) begin
            comp = t[0];
            tick();
            if (code != 10'd0 || busy) bad++;
        end
        check("idle_quiet", 32'(bad), 32'd0);

        // Upper rail: saturate, stay unlocked, release on a down step
        track_en = 1'b1;
        do_start();
        run_sar(2000, lat);
        check("sat_sar_code", 32'(code), 32'd1023);
        comp = 1'b1;
        for (int t = 0; t < 5; t++) tick();
        check("sat_hi_code", 32'(code), 32'd1023);
        check("sat_hi_flags", 32'({sat_hi, sat_lo}), 32'b10);
        for (int t = 0; t < 50; t++) tick();
        check("sat_hi_no_lock", 32'({lock, sat_hi}), 32'b01);
        comp = 1'b0;
        for (int t = 0; t < 5; t++) tick();
        check("sat_hi_release", 32'({sat_hi, code}), 32'd1022);

        // Lower rail
        do_start();
        run_sar(0, lat);
        comp = 1'b0;
        for (int t = 0; t < 5; t++) tick();
        check("sat_lo_state", 32'({sat_hi, sat_lo, code}), 32'b01_0000000000);

        // Restart mid-conversion
        track_en = 1'b0;
        do_start();
        for (int t = 0; t < 20; t++) begin
            comp = 1'($urandom_range(0, 1));
            tick();
        end
        do_start();
        check("restart_code", 32'(code), 32'd512);
        check("restart_busy", 32'(busy), 32'd1);
        lat = -1; bad = 0;
        for (int n = 1; n <= 100; n++) begin
            comp = 1'($urandom_range(0, 1));
            tick();
            if (sar_done) begin
                lat = n;
                break;
            end
            if (!busy) bad++;
        end
        check("restart_latency", 32'(lat), 32'd50);
        check("restart_busy_gap", 32'(bad), 32'd0);

        // HOLD freezes the code; enabling tracking resumes after a full settle
        track_en = 1'b0;
        do_start();
        run_sar(600, lat);
        bad = 0;
        for (int t = 0; t < 200; t++) begin
            comp = t[0];
            tick();
            if (code != 10'd599 || busy) bad++;
        end
        check("hold_stable", 32'(bad), 32'd0);
        track_en = 1'b1;
        comp = 1'b1;
        tick();
        for (int t = 0; t < 4; t++) tick();
        check("hold_resume_wait", 32'(code), 32'd599);
        tick();
        check("hold_resume_step", 32'(code), 32'd600);

        // Randomized comp against a step-level model
        for (int it = 0; it < 12; it++) begin
            te = 1'($urandom_range(0, 1));
            track_en = te;
            do_start();
            sar_val = 0; early = 0;
            for (int n = 1; n <= 50; n++) begin
                cb = 1'($urandom_range(0, 1));
                comp = cb;
                tick();
                if (n % 5 == 0) sar_val += int'(cb) << (10 - n / 5);
                if (sar_done && n != 50) early++;
            end
            check($sformatf("rnd%0d_sar_done", it), 32'({early[7:0], 7'd0, sar_done}), 32'd1);
            check($sformatf("rnd%0d_sar_code", it), 32'(code), 32'(sar_val));
            exp_c  = (32'd1 << (sar_val >> 6)) - 32'd1;
            exp_f1 = (32'd1 << ((sar_val >> 3) & 7)) - 32'd1;
            exp_f2 = (32'd1 << (sar_val & 7)) - 32'd1;
            m_code = sar_val; run = 0; lk = 1'b0; sh = 1'b0; sl = 1'b0; prev = 1'b0;
            for (int c = 51; c <= 130; c++) begin
                if ((c - 50) % 5 == 0)
                    cb = ($urandom_range(0, 3) != 0) ? !prev : 1'($urandom_range(0, 1));
                else
                    cb = 1'($urandom_range(0, 1));
                comp = cb;
                tick();
                if (c == 51)
                    check($sformatf("rnd%0d_therm", it), 32'({therm_c, therm_f1, therm_f2}),
                          (exp_c << 16) | (exp_f1 << 8) | exp_f2);
                if ((c - 50) % 5 == 0) begin
                    if (te) begin
                        if (cb && m_code == 1023) begin
                            sh = 1'b1; sl = 1'b0; run = 0;
                        end else if (!cb && m_code == 0) begin
                            sh = 1'b0; sl = 1'b1; run = 0;
                        end else begin
                            m_code = cb ? m_code + 1 : m_code - 1;
                            sh = 1'b0; sl = 1'b0;
                            run = (run > 0 && cb != prev) ? run + 1 : 1;
                        end
                        prev = cb;
                        if (run >= 8) lk = 1'b1;
                    end
                    exp_state = (32'(lk) << 12) | (32'(sh) << 11) | (32'(sl) << 10) | 32'(m_code);
                    check($sformatf("rnd%0d_step_c%0d", it, c), 32'({lock, sat_hi, sat_lo, code}), exp_state);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
